// File: rtl/irq_pending_ctrl_pkg.sv
// Shared types and helpers for the interrupt pending controller.
// Holds source count, ID width, FSM states and the clear-vector helper.
package irq_pending_ctrl_pkg;

   localparam int N_SRC = 8;
   localparam int ID_W  = 3;

   typedef enum logic {
      IDLE,
      PRESENT
   } state_e;

   function automatic logic [N_SRC-1:0] onehot8(input logic [ID_W-1:0] id);
      onehot8     = '0;
      onehot8[id] = 1'b1;
   endfunction

endpackage

// File: rtl/irq_pending_ctrl_prio_enc8.sv
// Combinational 8:3 priority encoder, highest set index wins.
// Ports: elig (candidates), win_id (winning index), any_v (any candidate set).
module prio_enc8
   import irq_pending_ctrl_pkg::*;
(
   input  logic [N_SRC-1:0] elig,
   output logic [ID_W-1:0]  win_id,
   output logic             any_v
);

   always_comb begin
      win_id = '0;
      any_v  = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         if (elig[k]) begin
            win_id = ID_W'(k);
            any_v  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Captures 8 request lines into a pending register and presents the
// highest-numbered unmasked source as a held ID over valid/ready.
// Ports: clk, rst_n (async, active-low), en, req, mask, irq_ready,
//        ovr_clr in; irq_valid, irq_id, pending, overrun out.
module irq_pending_ctrl
   import irq_pending_ctrl_pkg::*;
#(
   parameter bit EDGE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_SRC-1:0] req,
   input  logic [N_SRC-1:0] mask,
   input  logic             irq_ready,
   input  logic             ovr_clr,
   output logic             irq_valid,
   output logic [ID_W-1:0]  irq_id,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] overrun
);

   logic [N_SRC-1:0] req_d_q;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] overrun_q, overrun_d;
   logic [N_SRC-1:0] set_vec, clr_vec, elig;
   logic [ID_W-1:0]  win_id;
   logic             any_v;
   logic             hs;

   state_e           state_q;
   logic             valid_q;
   logic [ID_W-1:0]  id_q;

   assign hs      = valid_q & irq_ready;
   assign set_vec = EDGE ? (req & ~req_d_q) : req;
   assign clr_vec = hs ? onehot8(id_q) : '0;
   assign elig    = pending_q & ~mask;

   // Set is OR-ed in last so a same-cycle new event survives its clear.
   assign pending_d = (pending_q & ~clr_vec) | set_vec;

   // A new event on a source that is still pending (and not being
   // retired this cycle) is an overrun; a set beats ovr_clr.
   always_comb begin
      overrun_d = '0;
      if (EDGE) begin
         overrun_d = (ovr_clr ? '0 : overrun_q)
                   | (set_vec & pending_q & ~clr_vec);
      end
   end

   prio_enc8 u_enc (
      .elig   (elig),
      .win_id (win_id),
      .any_v  (any_v)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_d_q   <= '0;
         pending_q <= '0;
         overrun_q <= '0;
      end else begin
         req_d_q   <= req;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         id_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (en && any_v) begin
                  state_q <= PRESENT;
                  valid_q <= 1'b1;
                  id_q    <= win_id;
               end
            end
            PRESENT: begin
               // ID is frozen until accepted; en/mask/req are ignored here.
               if (irq_ready) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign irq_valid = valid_q;
   assign irq_id    = id_q;
   assign pending   = pending_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Scoreboard bench for irq_pending_ctrl, edge and level instances.
// Driver steps a reference model; monitor checks accepted IDs.
module tb_irq_pending_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       ready = 1'b0;
   logic       ovr_clr = 1'b0;
   logic [7:0] req = 8'h00;
   logic [7:0] mask = 8'h00;

   logic       v_o    [2];
   logic [2:0] id_o   [2];
   logic [7:0] pend_o [2];
   logic [7:0] ovr_o  [2];

   bit [7:0]   m_pend [2];
   bit [7:0]   m_ovr  [2];
   bit [7:0]   m_reqd [2];
   bit         m_v    [2];
   int         m_id   [2];
   int         q0[$];
   int         q1[$];

   int         nchk = 0;
   int         nerr = 0;

   always #5 clk = ~clk;

   irq_pending_ctrl #(.EDGE(1'b1)) u_edge (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mask(mask),
      .irq_ready(ready), .ovr_clr(ovr_clr),
      .irq_valid(v_o[0]), .irq_id(id_o[0]),
      .pending(pend_o[0]), .overrun(ovr_o[0])
   );

   irq_pending_ctrl #(.EDGE(1'b0)) u_lvl (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mask(mask),
      .irq_ready(ready), .ovr_clr(ovr_clr),
      .irq_valid(v_o[1]), .irq_id(id_o[1]),
      .pending(pend_o[1]), .overrun(ovr_o[1])
   );

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int winner(input bit [7:0] p, input bit [7:0] mk);
      winner = -1;
      for (int k = 0; k < 8; k++)
         if (p[k] && !mk[k]) winner = k;
   endfunction

   task automatic step(input int m);
      bit [7:0] sv, cv;
      bit       hs;
      int       w;
      hs = m_v[m] && ready;
      sv = (m == 0) ? (req & ~m_reqd[m]) : req;
      cv = hs ? 8'(1 << m_id[m]) : 8'h00;
      w  = winner(m_pend[m], mask);
      if (m == 0)
         m_ovr[m] = (ovr_clr ? 8'h00 : m_ovr[m]) | (sv & m_pend[m] & ~cv);
      else
         m_ovr[m] = 8'h00;
      m_pend[m] = (m_pend[m] & ~cv) | sv;
      m_reqd[m] = req;
      if (hs) begin
         if (m == 0) q0.push_back(m_id[m]);
         else        q1.push_back(m_id[m]);
      end
      if (m_v[m]) begin
         if (hs) m_v[m] = 1'b0;
      end else if (en && w >= 0) begin
         m_v[m]  = 1'b1;
         m_id[m] = w;
      end
   endtask

   task automatic cyc(input logic [7:0] r, input logic [7:0] mk,
                      input logic e, input logic rd, input logic oc);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("pending[%0d]", m), pend_o[m], m_pend[m]);
         chk($sformatf("overrun[%0d]", m), ovr_o[m], m_ovr[m]);
         chk($sformatf("valid[%0d]", m), v_o[m], m_v[m]);
         if (m_v[m]) chk($sformatf("id[%0d]", m), id_o[m], m_id[m]);
      end
      #1;
      req = r; mask = mk; en = e; ready = rd; ovr_clr = oc;
      step(0);
      step(1);
   endtask

   task automatic do_reset(input logic [7:0] r);
      @(negedge clk);
      #1;
      ready = 1'b0; en = 1'b1; mask = 8'h00; ovr_clr = 1'b0;
      req = r;
      rst_n = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk("rst valid", v_o[m], 0);
         chk("rst id", id_o[m], 0);
         chk("rst pending", pend_o[m], 0);
         chk("rst overrun", ovr_o[m], 0);
         m_pend[m] = '0; m_ovr[m] = '0; m_reqd[m] = '0;
         m_v[m] = 1'b0; m_id[m] = 0;
      end
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      step(0);
      step(1);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
   endtask

   // Monitor: compare every accepted ID against the scoreboard.
   initial begin
      int e;
      forever begin
         @(negedge clk);
         #3;
         if (rst_n && v_o[0] && ready) begin
            if (q0.size() == 0) chk("edge hs unexpected", 1, 0);
            else begin
               e = q0.pop_front();
               chk("edge hs id", id_o[0], e);
            end
         end
         if (rst_n && v_o[1] && ready) begin
            if (q1.size() == 0) chk("lvl hs unexpected", 1, 0);
            else begin
               e = q1.pop_front();
               chk("lvl hs id", id_o[1], e);
            end
         end
      end
   end

   initial begin
      do_reset(8'h00);
      drain(2);

      // single source
      cyc(8'h08, 8'h00, 1'b1, 1'b1, 1'b0);
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("single pend", pend_o[0], 8'h08);
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("single valid", v_o[0], 1);
      chk("single id", id_o[0], 3);
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("single clr", pend_o[0], 8'h00);
      drain(3);

      // priority ordering
      cyc(8'h81, 8'h00, 1'b1, 1'b1, 1'b0);
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("prio first", id_o[0], 7);
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("prio bubble", v_o[0], 0);
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("prio second", id_o[0], 0);
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("prio pend", pend_o[0], 8'h00);
      drain(2);

      // masking
      cyc(8'h90, 8'h80, 1'b1, 1'b1, 1'b0);
      cyc(8'h00, 8'h80, 1'b1, 1'b1, 1'b0);
      cyc(8'h00, 8'h80, 1'b1, 1'b1, 1'b0);
      chk("mask id", id_o[0], 4);
      cyc(8'h00, 8'h80, 1'b1, 1'b1, 1'b0);
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("mask pend", pend_o[0], 8'h80);
      chk("mask blocked", v_o[0], 0);
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("unmask id", id_o[0], 7);
      chk("unmask valid", v_o[0], 1);
      drain(3);

      // backpressure
      cyc(8'h04, 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(8'h40, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(8'h00, 8'h00, i[0], 1'b0, 1'b0);
         chk("hold id", id_o[0], 2);
      end
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("bp bubble", v_o[0], 0);
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("bp next", id_o[0], 6);
      drain(3);

      // overrun, then edge racing the handshake of the same source
      cyc(8'h04, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(8'h04, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("ovr set", ovr_o[0], 8'h04);
      cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("ovr clr", ovr_o[0], 8'h00);
      cyc(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(8'h04, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("race id", id_o[0], 2);
      cyc(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("race pend", pend_o[0][2], 1);
      chk("race ovr", ovr_o[0][2], 0);
      drain(4);

      // reset while presenting ID 5
      cyc(8'h20, 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("pre-rst id", id_o[0], 5);
      do_reset(8'h00);
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("post-rst valid", v_o[0], 0);

      // line high across reset release is an edge
      do_reset(8'h01);
      cyc(8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("rel edge pend", pend_o[0], 8'h01);
      drain(4);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(8'($urandom) & 8'($urandom) & 8'($urandom),
             ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
             $urandom_range(0, 7) != 0,
             1'($urandom),
             $urandom_range(0, 15) == 0);
      end
      drain(24);
      #5;
      chk("edge queue empty", q0.size(), 0);
      chk("lvl queue empty", q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
